branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
//  Fetch side: a combinational lookup on the current fetch PC drives predict_taken and
//  branch_target. The PC unit uses these to select the next PC in the same cycle.
//  Execute side: resolved control-flow outcomes (PC_e, taken, target) train the table
//  synchronously, closing the prediction/resolution loop.
// PARAMETERS
//  DATA_WIDTH  32  address/PC width in bits
//  ENTRIES     16  BTB entries; power of 2, >= 2
//  INDEX_BITS  $clog2(ENTRIES)  derived; do not override
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           asynchronous reset, active-high
//  PC             in   DATA_WIDTH  fetch-stage PC to look up
//  predict_taken  out  1           1 = predict taken; BTB hit and counter[1]==1
//  branch_target  out  DATA_WIDTH  predicted target; 0 on miss
//  upd_valid      in   1           execute stage resolved a branch/jump this cycle
//  upd_PC         in   DATA_WIDTH  PC of the resolved instruction (PC_e)
//  upd_taken      in   1           actual outcome (PCsrc of the resolving instruction)
//  upd_target     in   DATA_WIDTH  actual computed target (PC_fin + ImmOp)
//  hit            out  1           lookup hit, for debug/perf
// BEHAVIOUR
//  Address split: idx = PC[INDEX_BITS+1:2]; tag = PC[DATA_WIDTH-1:INDEX_BITS+2]; PC[1:0] ignored.
//  Entry fields: valid, tag, target[DATA_WIDTH-1:0], ctr[1:0].
//   ctr encoding: 00=SNT, 01=WNT, 10=WT, 11=ST.
//  Lookup: combinational, 0-cycle latency.
//   hit = valid[idx] && tag match.
//   predict_taken = hit & ctr[idx][1].
//   branch_target = hit ? target[idx] : 0.
//  Update: registered; takes effect on the clk edge where upd_valid=1.
//   Hit on uidx/utag:
//    taken: ctr increments, saturating at 11; target <= upd_target.
//    not taken: ctr decrements, saturating at 00; entry stays valid; target unchanged.
//   Miss, taken: allocate, overwriting any previous occupant.
//    valid=1, tag=utag, target=upd_target, ctr=10 (WT).
//   Miss, not taken: no state change (never allocate on not-taken).
//  Simultaneous lookup and update to the same idx in one cycle:
//   lookup returns the pre-update contents (read-old); the new value is visible next cycle.
//  Aliasing: different tags on the same idx evict each other; no replacement policy beyond overwrite.
//  Reset (async, any cycle, including mid-update):
//   all valid=0, ctr=01, target=0, tag=0.
//   Outputs immediately predict_taken=0, branch_target=0, hit=0.
//   An upd_valid coincident with rst is dropped.
//  Correctness: the predictor is advisory only; a mispredict is corrected by the execute-stage redirect.
//   No output may be X after reset, regardless of PC.
// TESTING
//  1 Reset then PC=0x100 -> predict_taken=0, branch_target=0, hit=0.
//  2 upd_valid, upd_PC=0x100, taken=1, target=0x200; next cycle PC=0x100 -> hit=1, predict_taken=1, branch_target=0x200 (ctr=10).
//  3 Training from test 2:
//    - one not-taken update on 0x100 -> ctr=01, predict_taken=0, hit=1, target still 0x200;
//    - two further not-taken updates -> ctr saturates at 00;
//    - three taken updates -> ctr=11;
//    - a 4th taken update -> still 11, predict_taken=1.
//  4 Alias (ENTRIES=16): entry 0x100 valid; taken update 0x140 target 0x300 (same idx 0) ->
//    - PC=0x100 -> hit=0;
//    - PC=0x140 -> branch_target=0x300.
//    Not-taken update on 0x180 -> no allocation, PC=0x180 hit=0.
//  5 Same-cycle hazard: PC=upd_PC=0x100 (entry ctr=01), update taken -> that cycle predict_taken=0; next cycle predict_taken=1.
//  6 Assert rst mid-cycle with upd_valid=1 on populated table -> outputs drop to 0 asynchronously; after release every PC misses.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a 2-bit
// saturating counter per entry.
//   Fetch side : PC -> hit / predict_taken / branch_target, purely combinational.
//   Execute    : upd_valid/upd_PC/upd_taken/upd_target train the table on clk.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   PC                fetch PC to look up
//   predict_taken     hit && counter MSB
//   branch_target     stored target on hit, 0 on miss
//   hit               lookup hit (debug/perf)
//   upd_valid         a branch/jump resolved this cycle
//   upd_PC            PC of the resolving instruction
//   upd_taken         actual outcome
//   upd_target        actual target
// PC[1:0] is ignored on both sides; idx = PC[INDEX_BITS+1:2], tag = upper bits.

// One BTB entry. Owns valid/tag/target/counter and its own update rule, so the
// top only has to steer the update strobe to the indexed entry.
module btb_entry #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_upd,
  input  logic                  i_taken,
  input  logic [TAG_W-1:0]      i_tag,
  input  logic [DATA_WIDTH-1:0] i_target,
  output logic                  o_valid,
  output logic [TAG_W-1:0]      o_tag,
  output logic [DATA_WIDTH-1:0] o_target,
  output logic [1:0]            o_ctr
);
  logic                  r_valid;
  logic [TAG_W-1:0]      r_tag;
  logic [DATA_WIDTH-1:0] r_target;
  logic [1:0]            r_ctr;
  logic                  w_hit;

  assign w_hit = r_valid && (r_tag == i_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= 2'b01;
    end else if (i_upd) begin
      if (w_hit) begin
        if (i_taken) begin
          if (r_ctr != 2'b11) r_ctr <= r_ctr + 2'd1;
          r_target <= i_target;
        end else if (r_ctr != 2'b00) begin
          r_ctr <= r_ctr - 2'd1;
        end
      end else if (i_taken) begin
        // Allocate on taken miss, evicting whatever alias lived here.
        r_valid  <= 1'b1;
        r_tag    <= i_tag;
        r_target <= i_target;
        r_ctr    <= 2'b10;
      end
      // Not-taken miss: never allocate.
    end
  end

  assign o_valid  = r_valid;
  assign o_tag    = r_tag;
  assign o_target = r_target;
  assign o_ctr    = r_ctr;
endmodule

module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_PC,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  output logic                  hit
);
  localparam int TAG_W = DATA_WIDTH - INDEX_BITS - 2;

  logic [INDEX_BITS-1:0]               w_idx, w_uidx;
  logic [TAG_W-1:0]                    w_tag, w_utag;
  logic [ENTRIES-1:0]                  w_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]       w_tags;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0]  w_targets;
  logic [ENTRIES-1:0][1:0]             w_ctrs;
  logic                                w_hit;
  logic                                w_unused_lsbs;

  assign w_idx  = PC[INDEX_BITS+1:2];
  assign w_tag  = PC[DATA_WIDTH-1:INDEX_BITS+2];
  assign w_uidx = upd_PC[INDEX_BITS+1:2];
  assign w_utag = upd_PC[DATA_WIDTH-1:INDEX_BITS+2];
  assign w_unused_lsbs = ^{PC[1:0], upd_PC[1:0]};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    btb_entry #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAG_W     (TAG_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .i_upd   (upd_valid && (w_uidx == INDEX_BITS'(g))),
      .i_taken (upd_taken),
      .i_tag   (w_utag),
      .i_target(upd_target),
      .o_valid (w_valid[g]),
      .o_tag   (w_tags[g]),
      .o_target(w_targets[g]),
      .o_ctr   (w_ctrs[g])
    );
  end

  // Lookup reads the registered state directly, so a same-cycle update to the
  // same index is seen only from the next cycle (read-old).
  assign w_hit         = w_valid[w_idx] && (w_tags[w_idx] == w_tag);
  assign hit           = w_hit;
  assign predict_taken = w_hit && w_ctrs[w_idx][1];
  assign branch_target = w_hit ? w_targets[w_idx] : '0;
endmodule
